// File: rtl/cs_pkg.sv
// rtl/cs_pkg.sv - shared widths, sample/window types and max helper for cs_comparator_selector
package cs_pkg;

    localparam int DATA_W = 8;
    localparam int WIN    = 9;
    localparam int SUM_W  = 12;
    localparam int Y_W    = 10;
    localparam int YF_W   = 13;

    typedef logic [DATA_W-1:0] sample_t;
    typedef sample_t window_t [WIN];

    function automatic sample_t max2(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cs_appr_select.sv
// rtl/cs_appr_select.sv - largest window sample not exceeding the average
module cs_appr_select
    import cs_pkg::*;
(
    input  window_t win,
    input  sample_t avg,
    output sample_t xappr
);

    sample_t masked [WIN];
    sample_t lvl1   [5];
    sample_t lvl2   [3];
    sample_t lvl3   [2];

    // Samples above the average are forced to zero; zero never wins over a
    // qualifying sample, and the window minimum always qualifies.
    always_comb begin
        for (int k = 0; k < WIN; k++) begin
            masked[k] = (win[k] <= avg) ? win[k] : '0;
        end
    end

    // Balanced max tree: 9 -> 5 -> 3 -> 2 -> 1.
    always_comb begin
        lvl1[0] = max2(masked[0], masked[1]);
        lvl1[1] = max2(masked[2], masked[3]);
        lvl1[2] = max2(masked[4], masked[5]);
        lvl1[3] = max2(masked[6], masked[7]);
        lvl1[4] = masked[8];
        lvl2[0] = max2(lvl1[0], lvl1[1]);
        lvl2[1] = max2(lvl1[2], lvl1[3]);
        lvl2[2] = lvl1[4];
        lvl3[0] = max2(lvl2[0], lvl2[1]);
        lvl3[1] = lvl2[2];
        xappr   = max2(lvl3[0], lvl3[1]);
    end

endmodule

// File: rtl/cs_comparator_selector.sv
// rtl/cs_comparator_selector.sv - 9-sample sliding-window comparator/selector; CS_OUT_REG_EN registers Y
module cs_comparator_selector
    import cs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] X,
    output logic [Y_W-1:0]    Y
);

    window_t          win_q;
    window_t          win_d;
    logic [SUM_W-1:0] sum;
    sample_t          avg;
    sample_t          xappr;
    logic [YF_W-1:0]  y_full;
    logic [Y_W-1:0]   y_comb;

    // Next window: new sample enters slot 0, everything ages by one slot.
    always_comb begin
        win_d[0] = X;
        for (int k = 1; k < WIN; k++) begin
            win_d[k] = win_q[k-1];
        end
    end

    // Window shift register, cleared asynchronously so Y drops to 0 at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q <= '{default: '0};
        end else begin
            win_q <= win_d;
        end
    end

    // Window sum and exact floor division by the window depth.
    always_comb begin
        sum = '0;
        for (int k = 0; k < WIN; k++) begin
            sum = sum + SUM_W'(win_q[k]);
        end
        avg = DATA_W'(sum / SUM_W'(WIN));
    end

    cs_appr_select u_appr_select (
        .win   (win_q),
        .avg   (avg),
        .xappr (xappr)
    );

    // Y = floor((sum + 9*Xappr) / 8); 9*Xappr built as (Xappr << 3) + Xappr.
    always_comb begin
        y_full = {1'b0, sum} + (YF_W'(xappr) << 3) + YF_W'(xappr);
        y_comb = y_full[YF_W-1:3];
    end

`ifdef CS_OUT_REG_EN
    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] y_d;

    // Output register input is simply the combinational result.
    always_comb begin
        y_d = y_comb;
    end

    // Output register adds one cycle of latency and clears with the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;
`else
    assign Y = y_comb;
`endif

endmodule

// File: tb/tb_cs_comparator_selector.sv
// tb/tb_cs_comparator_selector.sv - scoreboard bench for cs_comparator_selector
module tb_cs_comparator_selector;

    logic       clk;
    logic       reset;
    logic [7:0] x_in;
    logic [9:0] y_out;

    int total = 0;
    int bad   = 0;

    int exp_q [$];
    int name_q [$];
    int model_win [$];

    cs_comparator_selector dut (
        .clk   (clk),
        .reset (reset),
        .X     (x_in),
        .Y     (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic straight from the window rules; missing slots are zero.
    function automatic int model_y();
        int s;
        int a;
        int xa;
        s  = 0;
        xa = 0;
        foreach (model_win[i]) s += model_win[i];
        a = s / 9;
        foreach (model_win[i]) begin
            if (model_win[i] <= a && model_win[i] > xa) xa = model_win[i];
        end
        return (s + 9 * xa) / 8;
    endfunction

    task automatic sb_reset();
        exp_q.delete();
        name_q.delete();
`ifdef CS_OUT_REG_EN
        exp_q.push_back(0);
        name_q.push_back(0);
`endif
    endtask

    // One capture with reset released; exp < 0 means use the model.
    task automatic step(input int x, input int exp, input int tag);
        int m;
        @(negedge clk);
        reset = 1'b1;
        x_in  = 8'(x);
        model_win.push_front(x);
        if (model_win.size() > 9) void'(model_win.pop_back());
        m = model_y();
        exp_q.push_back((exp >= 0) ? exp : m);
        name_q.push_back(tag);
    endtask

    // One cycle held in reset: window stays empty, output stays 0.
    task automatic step_rst();
        @(negedge clk);
        reset = 1'b0;
        x_in  = 8'($urandom_range(0, 255));
        model_win.delete();
        exp_q.push_back(0);
        name_q.push_back(1);
    endtask

    // Monitor: Y is presented every cycle; compare just after the edge.
    initial begin
        int e;
        int t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = name_q.pop_front();
                total++;
                if (int'(y_out) !== e) begin
                    bad++;
                    $display("FAIL y_tag%0d t=%0t got=%0d want=%0d", t, $time, y_out, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        x_in  = 8'd0;
        sb_reset();
        #1;
        total++;
        if (y_out !== 10'd0) begin
            bad++;
            $display("FAIL reset_y got=%0d want=0", y_out);
        end
        repeat (3) step_rst();

        for (int i = 0; i < 9; i++) step(10, (i == 8) ? 22 : -1, 10);
        for (int i = 1; i <= 9; i++) step(i, (i == 9) ? 11 : -1, 20);
        for (int i = 0; i < 9; i++) step(255, (i == 8) ? 573 : -1, 30);
        for (int i = 0; i < 8; i++) step(0, -1, 40);
        step(255, 31, 41);
        step(255, 63, 42);

        for (int i = 0; i < 20; i++) step(int'($urandom_range(0, 255)), -1, 50);

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (y_out !== 10'd0) begin
            bad++;
            $display("FAIL midreset_y got=%0d want=0", y_out);
        end
        model_win.delete();
        sb_reset();
        repeat (2) step_rst();
        for (int i = 0; i < 9; i++) step(20, (i == 8) ? 45 : -1, 60);

        for (int i = 0; i < 40; i++) step(int'($urandom_range(0, 255)), -1, 70);
        for (int i = 0; i < 20; i++) step(int'($urandom_range(0, 3)) * 85, -1, 80);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cs_comparator_selector.md
Name: cs_comparator_selector

Overview:
- Streaming comparator/selector: each clock it accepts one 8-bit sample X and keeps a sliding window of the 9 most recent samples.
- It computes the window average, then selects the approximate value Xappr: the largest window sample that is ≤ the average.
- Output Y = floor((sum of window + 9·Xappr) / 8).
- Sits as a standalone datapath block fed by a sample source; no handshake.

Parameters:
- DATA_W, 8, sample width of X.
- WIN, 9, window depth (fixed at 9; divisor 9 and factor 9 are tied to it).
- Y_W, 10, output width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears the window.
- X  input  8  unsigned sample; captured every rising edge.
- Y  output  10  unsigned result for the current window.

Behaviour:
- Window register:
  - 9 × 8-bit shift register W[0..8].
  - On each rising clk with reset high: W[0] ← X, W[k] ← W[k-1]; the oldest sample is discarded.
- Reset:
  - Asserting reset low clears all W to 0 immediately, without waiting for clk.
  - Y therefore drops to 0 combinationally.
  - Applies mid-stream as well: the window refills from zero after release.
- Arithmetic (combinational from W only; X never feeds Y directly):
  - sum = Σ W[k]: 12-bit unsigned, max 2295.
  - avg = floor(sum / 9): 8-bit. Exact integer division; no approximation allowed.
  - Xappr = max{ W[k] : W[k] ≤ avg }. One always exists because min ≤ avg. Duplicate values are irrelevant.
  - Y = floor((sum + 9·Xappr) / 8): 13-bit intermediate, truncating right shift by 3. Max result 573, which fits 10 bits.
- Latency:
  - Y reflects the window after the capturing edge and is stable for the whole following cycle.
  - Y becomes meaningful from the cycle after the 9th sample is captured.
  - Earlier cycles compute with zeros in unfilled slots; this is deterministic, not X/undefined.
- Output timing: Y changes only after the rising clk edge (clk-to-q plus logic) and must be settled ≥0.5 ns before the next rising edge. Target clock period 9.96 ns.
- No overflow or saturation cases exist within the stated widths.

Optional Feature:
- Macro CS_OUT_REG_EN.
- Defined: Y is driven from a 10-bit register loaded each rising edge with the combinational result. This adds one cycle of latency. The register is cleared to 0 by the asynchronous reset.
- Undefined: Y is purely combinational from the window registers, as described above.

Decomposition:
- Package cs_pkg holds:
  - Constants: DATA_W=8, WIN=9, SUM_W=12, Y_W=10.
  - Typedef sample_t as logic [7:0].
  - Typedef window_t as sample_t [WIN].
- One sub-module, cs_appr_select:
  - Inputs: window_t and avg.
  - Output: Xappr.
  - Implemented as per-sample ≤avg comparisons feeding a masked max-reduction tree.
- The top holds the shift register, adder tree, divide-by-9, final add/shift, and the optional output register.

Test Plan:
- Hold reset low, then release; drive X=10 for 9 cycles → Y=0 during reset; after the 9th capture Y=22 (sum 90, avg 10, Xappr 10, 180/8).
- Drive X=1,2,…,9 → sum 45, avg 5, Xappr 5, Y=11.
- Drive X=255 ×9 → Y=573, the maximum; check there is no width overflow.
- Drive X=0 ×8 then 255 → sum 255, avg 28, Xappr 0, Y=31. Next feed 255 once more (window now holds 0 ×7 and 255 ×2) → sum 510, avg 56, Xappr 0, Y=63.
- Fill with a random stream, then pull reset low mid-cycle (away from any clk edge) → Y=0 immediately. After release plus 9 samples of 20 → Y=45 (sum 180, avg 20, Xappr 20, 360/8).
- With CS_OUT_REG_EN defined, repeat scenario 2 → Y=11 appears exactly one cycle later than in the combinational build.
